mips_cpu_bus_arbiter: RTL and testbench
=======================================

# mips_cpu_bus_arbiter

Two-master to one-slave arbiter for the CPU memory bus. It shares the single Avalon-style memory port (`read`/`write`/`byteenable`/`addr`/`writedata`/`waitrequest`/`readdata`, registered read data one cycle after acceptance) between the instruction-fetch master (m0) and the load/store master (m1). Grants are round-robin, one transaction per grant. The block routes the returned read data to the owning master with a `readdatavalid` strobe.

## Interface
- `ADDR_W`, 32, address width on all ports.
- `clk` input 1: single clock, all state on rising edge.
- `reset` input 1: asynchronous, active-high.
- `m0_read`, `m0_write` input 1 each: master 0 request.
- `m0_addr` input ADDR_W: master 0 word-aligned byte address.
- `m0_byteenable` input 4: master 0 lane enables.
- `m0_writedata` input 32: master 0 write data.
- `m0_waitrequest` output 1: master 0 stall.
- `m0_readdata` output 32: master 0 read data.
- `m0_readdatavalid` output 1: master 0 read data strobe.
- `m1_*`: same set as `m0_*`, for master 1.
- `s_read`, `s_write` output 1 each: slave request.
- `s_addr` output ADDR_W: slave address.
- `s_byteenable` output 4: slave lane enables.
- `s_writedata` output 32: slave write data.
- `s_waitrequest` input 1: slave stall.
- `s_readdata` input 32: slave read data, valid the cycle after a read is accepted.

## Operation
- FSM states: IDLE, GNT0, GNT1. Reset state is IDLE.
- A master is requesting when its `read` or `write` is high.
- IDLE, only one master requesting: go to that master's GNT state.
- IDLE, both requesting: grant the master not in `last_grant`. `last_grant` resets to 1, so m0 wins the first tie.
- IDLE, no requests: stay in IDLE.
- GNTx: slave outputs are driven combinationally from master x. Outside GNT states, `s_read`=`s_write`=0; `s_addr`, `s_byteenable` and `s_writedata` are 0.
- Accept condition: in GNTx with (`s_read`|`s_write`) & !`s_waitrequest`. On accept:
  - `mx_waitrequest`=0 for that cycle.
  - Next state is IDLE.
  - `last_grant`<=x.
  - If the transfer was a read, set `rd_pend`<=1 and `rd_owner`<=x.
- If master x drops both `read` and `write` while in GNTx (protocol violation), return to IDLE and leave `last_grant` unchanged.
- `mx_waitrequest`=1 whenever master x is requesting and its transfer is not being accepted this cycle. It is 0 when master x is not requesting.
- Both `read` and `write` high on the granted master: forward the write only (`s_read`=0). The master sees one accepted transaction, with no read data returned.
- Read return:
  - `rd_pend` clears the cycle after it is set.
  - While `rd_pend`=1, `m{rd_owner}_readdatavalid`=1 and `m{rd_owner}_readdata`=`s_readdata`.
  - The other master's `readdatavalid`=0. Any `readdata` without a valid strobe is 0.
- Masters hold all request signals stable while their waitrequest is high. The arbiter does not latch request fields.

## Timing
- Reset (asynchronous assert):
  - State=IDLE, `last_grant`=1, `rd_pend`=0, `rd_owner`=0.
  - All `s_*` outputs 0, both `readdatavalid` 0, `readdata` 0.
  - `mx_waitrequest` follows its combinational rule.
- Minimum access, measured from a request first seen in IDLE at cycle 0:
  - Cycle 1: GNTx, and the slave accepts if `s_waitrequest`=0.
  - Cycle 2: `readdatavalid` for a read; state is back in IDLE.
  - Cycle 3: earliest next grant.
  - Throughput: one transaction per 2 cycles.
- Slave stall: every cycle of `s_waitrequest`=1 extends GNTx by one cycle.
- Read-data return does not block arbitration. A new grant in the IDLE cycle coincides with the return strobe.
- Reset during GNTx or with `rd_pend` set: the transaction is abandoned and no `readdatavalid` is produced.

## Test plan
- Single read: m0 reads addr 0x100 (byteenable 4'b1111), slave holds 0xDEADBEEF, `s_waitrequest`=0.
  - Expect `s_read`=1 in cycle 1.
  - Expect `m0_readdatavalid`=1 with data 0xDEADBEEF in cycle 2.
  - Expect m1 outputs unchanged.
- Tie and round-robin: both masters request continuously from reset.
  - Expect grant order m0, m1, m0, m1 over 4 transactions.
  - Expect each master's waitrequest to drop exactly once per 4 cycles.
- Write then read from m1: write 0x12345678 with byteenable 4'b0011 to 0x200, then read 0x200 with byteenable 4'b1111.
  - Expect `m1_readdata`=0x00005678 from a zero-initialised slave.
- Slave stall: `s_waitrequest` held high 3 cycles during GNT1.
  - Expect `m1_waitrequest`=1 for those cycles.
  - Expect m0 (also requesting) not granted until m1 is accepted.
- Return overlap: m0 read accepted, m1 requesting.
  - In the next cycle, expect `m0_readdatavalid`=1 while m1 is granted that same cycle.
  - Expect `m1_readdatavalid`=0.
- Reset mid-GNT0 with a read in flight: assert `reset` asynchronously.
  - Expect immediate IDLE, `s_read`=0, no `readdatavalid` afterwards.
  - After release, expect the first tie to go to m0.

Source files
------------

// File: rtl/mips_cpu_bus_arbiter.sv
// rtl/mips_cpu_bus_arbiter.sv - round-robin two-master arbiter for the shared CPU memory port
module mips_cpu_bus_arbiter #(
    parameter int ADDR_W = 32
) (
    input  logic              clk,
    input  logic              reset,

    input  logic              m0_read,
    input  logic              m0_write,
    input  logic [ADDR_W-1:0] m0_addr,
    input  logic [3:0]        m0_byteenable,
    input  logic [31:0]       m0_writedata,
    output logic              m0_waitrequest,
    output logic [31:0]       m0_readdata,
    output logic              m0_readdatavalid,

    input  logic              m1_read,
    input  logic              m1_write,
    input  logic [ADDR_W-1:0] m1_addr,
    input  logic [3:0]        m1_byteenable,
    input  logic [31:0]       m1_writedata,
    output logic              m1_waitrequest,
    output logic [31:0]       m1_readdata,
    output logic              m1_readdatavalid,

    output logic              s_read,
    output logic              s_write,
    output logic [ADDR_W-1:0] s_addr,
    output logic [3:0]        s_byteenable,
    output logic [31:0]       s_writedata,
    input  logic              s_waitrequest,
    input  logic [31:0]       s_readdata
);

    typedef enum logic [1:0] {IDLE, GNT0, GNT1} state_t;

    state_t state, state_nxt;
    logic   last_grant;
    logic   rd_pend;
    logic   rd_owner;
    logic   req0, req1;
    logic   accept;

    assign req0 = m0_read | m0_write;
    assign req1 = m1_read | m1_write;

    always_comb begin
        s_read       = 1'b0;
        s_write      = 1'b0;
        s_addr       = '0;
        s_byteenable = '0;
        s_writedata  = '0;
        state_nxt    = state;

        // A simultaneous read+write is forwarded as the write alone.
        case (state)
            GNT0: begin
                s_write      = m0_write;
                s_read       = m0_read & ~m0_write;
                s_addr       = m0_addr;
                s_byteenable = m0_byteenable;
                s_writedata  = m0_writedata;
            end
            GNT1: begin
                s_write      = m1_write;
                s_read       = m1_read & ~m1_write;
                s_addr       = m1_addr;
                s_byteenable = m1_byteenable;
                s_writedata  = m1_writedata;
            end
            default: ;
        endcase

        accept = (s_read | s_write) & ~s_waitrequest;

        case (state)
            IDLE: begin
                if (req0 && req1) state_nxt = last_grant ? GNT0 : GNT1;
                else if (req0)    state_nxt = GNT0;
                else if (req1)    state_nxt = GNT1;
            end
            GNT0:    if (!req0 || accept) state_nxt = IDLE;
            GNT1:    if (!req1 || accept) state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase

        m0_waitrequest   = req0 & ~((state == GNT0) & accept);
        m1_waitrequest   = req1 & ~((state == GNT1) & accept);

        m0_readdatavalid = rd_pend & ~rd_owner;
        m1_readdatavalid = rd_pend & rd_owner;
        m0_readdata      = m0_readdatavalid ? s_readdata : 32'h0;
        m1_readdata      = m1_readdatavalid ? s_readdata : 32'h0;
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state      <= IDLE;
            last_grant <= 1'b1;
            rd_pend    <= 1'b0;
            rd_owner   <= 1'b0;
        end else begin
            state   <= state_nxt;
            rd_pend <= 1'b0;
            // accept is only ever high in a grant state, so GNT1 identifies the owner.
            if (accept) begin
                last_grant <= (state == GNT1);
                if (s_read) begin
                    rd_pend  <= 1'b1;
                    rd_owner <= (state == GNT1);
                end
            end
        end
    end

endmodule

// File: tb/tb_mips_cpu_bus_arbiter.sv
// tb/tb_mips_cpu_bus_arbiter.sv - self-checking bench for mips_cpu_bus_arbiter
module tb_mips_cpu_bus_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_read, m0_write, m1_read, m1_write;
    logic [31:0] m0_addr, m1_addr, m0_writedata, m1_writedata;
    logic [3:0]  m0_byteenable, m1_byteenable;
    logic        m0_waitrequest, m1_waitrequest, m0_readdatavalid, m1_readdatavalid;
    logic [31:0] m0_readdata, m1_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [31:0] s_addr, s_writedata, s_readdata;
    logic [3:0]  s_byteenable;

    always #5 clk = ~clk;

    mips_cpu_bus_arbiter #(.ADDR_W(32)) dut (
        .clk(clk), .reset(reset),
        .m0_read(m0_read), .m0_write(m0_write), .m0_addr(m0_addr),
        .m0_byteenable(m0_byteenable), .m0_writedata(m0_writedata),
        .m0_waitrequest(m0_waitrequest), .m0_readdata(m0_readdata),
        .m0_readdatavalid(m0_readdatavalid),
        .m1_read(m1_read), .m1_write(m1_write), .m1_addr(m1_addr),
        .m1_byteenable(m1_byteenable), .m1_writedata(m1_writedata),
        .m1_waitrequest(m1_waitrequest), .m1_readdata(m1_readdata),
        .m1_readdatavalid(m1_readdatavalid),
        .s_read(s_read), .s_write(s_write), .s_addr(s_addr),
        .s_byteenable(s_byteenable), .s_writedata(s_writedata),
        .s_waitrequest(s_waitrequest), .s_readdata(s_readdata)
    );

    typedef struct {
        logic        r0, w0, r1, w1;
        logic [31:0] a0, a1;
        logic [3:0]  be0, be1;
        logic [31:0] wd0, wd1;
        logic        sw;
        logic [1:0]  gnt;      // 0 none, 1 m0, 2 m1
        logic        wt0, wt1;
        logic [31:0] rdat;     // data expected back if this row completes a read
    } vec_t;

    typedef struct {
        logic        owner;
        logic [31:0] data;
    } sb_t;

    vec_t        vecs[$];
    sb_t         sb[$];
    logic [31:0] mem [logic [31:0]];
    int          checks   = 0;
    int          failures = 0;
    logic [31:0] junk     = 32'hA5A5_0000;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic add(input logic r0, input logic w0, input logic r1, input logic w1,
                       input logic [31:0] a0, input logic [31:0] a1,
                       input logic [3:0] be0, input logic [3:0] be1,
                       input logic [31:0] wd0, input logic [31:0] wd1,
                       input logic sw, input logic [1:0] gnt,
                       input logic wt0, input logic wt1, input logic [31:0] rdat);
        vec_t v;
        v.r0 = r0; v.w0 = w0; v.r1 = r1; v.w1 = w1; v.a0 = a0; v.a1 = a1;
        v.be0 = be0; v.be1 = be1; v.wd0 = wd0; v.wd1 = wd1; v.sw = sw;
        v.gnt = gnt; v.wt0 = wt0; v.wt1 = wt1; v.rdat = rdat;
        vecs.push_back(v);
    endtask

    task automatic add_idle();
        add(0,0,0,0, 0,0, 0,0, 0,0, 0, 0, 0,0, 0);
    endtask

    task automatic add_both(input logic sw, input logic [1:0] gnt, input logic wt0,
                            input logic wt1, input logic [31:0] rdat);
        add(1,0,1,0, 32'h100,32'h200, 4'hF,4'hF, 0,0, sw, gnt, wt0,wt1, rdat);
    endtask

    // Slave model: samples the bus at the negedge, commits at the following posedge.
    task automatic cycle_end();
        logic        acc_r, acc_w;
        logic [31:0] ad, wd, word;
        logic [3:0]  be;
        acc_r = s_read & ~s_waitrequest;
        acc_w = s_write & ~s_waitrequest;
        ad = s_addr; wd = s_writedata; be = s_byteenable;
        @(posedge clk);
        #1;
        if (acc_w) begin
            word = mem.exists(ad) ? mem[ad] : 32'h0;
            for (int b = 0; b < 4; b++)
                if (be[b]) word[8*b +: 8] = wd[8*b +: 8];
            mem[ad] = word;
        end
        if (acc_r) s_readdata = mem.exists(ad) ? mem[ad] : 32'h0;
        else begin
            junk = junk + 32'h0000_0101;
            s_readdata = junk;
        end
    endtask

    task automatic check_row(input vec_t v, input int i);
        logic        er, ew, acc;
        logic [31:0] ea, ewd;
        logic [3:0]  ebe;
        logic        have;
        sb_t         e;
        er = 0; ew = 0; ea = 0; ewd = 0; ebe = 0;
        if (v.gnt == 2'd1) begin
            er = v.r0 & ~v.w0; ew = v.w0; ea = v.a0; ebe = v.be0; ewd = v.wd0;
        end else if (v.gnt == 2'd2) begin
            er = v.r1 & ~v.w1; ew = v.w1; ea = v.a1; ebe = v.be1; ewd = v.wd1;
        end
        chk($sformatf("v%0d s_read", i), {31'b0, s_read}, {31'b0, er});
        chk($sformatf("v%0d s_write", i), {31'b0, s_write}, {31'b0, ew});
        chk($sformatf("v%0d s_addr", i), s_addr, ea);
        chk($sformatf("v%0d s_byteenable", i), {28'b0, s_byteenable}, {28'b0, ebe});
        chk($sformatf("v%0d s_writedata", i), s_writedata, ewd);
        chk($sformatf("v%0d m0_waitrequest", i), {31'b0, m0_waitrequest}, {31'b0, v.wt0});
        chk($sformatf("v%0d m1_waitrequest", i), {31'b0, m1_waitrequest}, {31'b0, v.wt1});

        have = (sb.size() > 0);
        e.owner = 0; e.data = 0;
        if (have) e = sb.pop_front();
        chk($sformatf("v%0d m0_readdatavalid", i), {31'b0, m0_readdatavalid}, {31'b0, have & ~e.owner});
        chk($sformatf("v%0d m1_readdatavalid", i), {31'b0, m1_readdatavalid}, {31'b0, have & e.owner});
        chk($sformatf("v%0d m0_readdata", i), m0_readdata, (have && !e.owner) ? e.data : 32'h0);
        chk($sformatf("v%0d m1_readdata", i), m1_readdata, (have && e.owner) ? e.data : 32'h0);

        acc = (v.gnt != 2'd0) && (er || ew) && !v.sw;
        if (acc && er) begin
            e.owner = (v.gnt == 2'd2);
            e.data  = v.rdat;
            sb.push_back(e);
        end
    endtask

    initial begin
        // single read by m0
        add(1,0,0,0, 32'h100,0, 4'hF,0, 0,0, 0, 0, 1,0, 0);
        add(1,0,0,0, 32'h100,0, 4'hF,0, 0,0, 0, 1, 0,0, 32'hDEADBEEF);
        add_idle(); add_idle();
        // m1 partial write then read back
        add(0,0,0,1, 0,32'h200, 0,4'h3, 0,32'h12345678, 0, 0, 0,1, 0);
        add(0,0,0,1, 0,32'h200, 0,4'h3, 0,32'h12345678, 0, 2, 0,0, 0);
        add(0,0,1,0, 0,32'h200, 0,4'hF, 0,0, 0, 0, 0,1, 0);
        add(0,0,1,0, 0,32'h200, 0,4'hF, 0,0, 0, 2, 0,0, 32'h00005678);
        add_idle();
        // slave stalls GNT1 for 3 cycles while m0 waits
        add(0,0,1,0, 0,32'h200, 0,4'hF, 0,0, 0, 0, 0,1, 0);
        for (int k = 0; k < 3; k++) add_both(1, 2, 1,1, 0);
        add_both(0, 2, 1,0, 32'h00005678);
        add(1,0,0,0, 32'h100,0, 4'hF,0, 0,0, 0, 0, 1,0, 0);
        add(1,0,0,0, 32'h100,0, 4'hF,0, 0,0, 0, 1, 0,0, 32'hDEADBEEF);
        // m0 return strobe overlaps m1 arbitration
        add(0,0,1,0, 0,32'h200, 0,4'hF, 0,0, 0, 0, 0,1, 0);
        add(0,0,1,0, 0,32'h200, 0,4'hF, 0,0, 0, 2, 0,0, 32'h00005678);
        add_idle();
        // continuous tie: m0, m1, m0, m1
        for (int k = 0; k < 2; k++) begin
            add_both(0, 0, 1,1, 0);
            add_both(0, 1, 0,1, 32'hDEADBEEF);
            add_both(0, 0, 1,1, 0);
            add_both(0, 2, 1,0, 32'h00005678);
        end
        add_idle();
        // read+write together forwards the write only
        add(1,1,0,0, 32'h300,0, 4'hF,0, 32'hCAFEF00D,0, 0, 0, 1,0, 0);
        add(1,1,0,0, 32'h300,0, 4'hF,0, 32'hCAFEF00D,0, 0, 1, 0,0, 0);
        add(1,0,0,0, 32'h300,0, 4'hF,0, 0,0, 0, 0, 1,0, 0);
        add(1,0,0,0, 32'h300,0, 4'hF,0, 0,0, 0, 1, 0,0, 32'hCAFEF00D);
        add_idle();
        // m1 abandons its grant; last_grant stays m0 so the next tie goes to m1
        add(0,0,1,0, 0,32'h200, 0,4'hF, 0,0, 0, 0, 0,1, 0);
        add(0,0,0,0, 0,0, 0,0, 0,0, 0, 2, 0,0, 0);
        add_both(0, 0, 1,1, 0);
        add_both(0, 2, 1,0, 32'h00005678);
        add_both(0, 0, 1,1, 0);
        add_both(0, 1, 0,1, 32'hDEADBEEF);
        add_idle();

        mem[32'h100] = 32'hDEADBEEF;
        reset = 1'b1;
        m0_read = 0; m0_write = 0; m0_addr = 0; m0_byteenable = 0; m0_writedata = 0;
        m1_read = 0; m1_write = 0; m1_addr = 0; m1_byteenable = 0; m1_writedata = 0;
        s_waitrequest = 0; s_readdata = 32'h0;

        #2;
        chk("rst s_read", {31'b0, s_read}, 32'h0);
        chk("rst s_write", {31'b0, s_write}, 32'h0);
        chk("rst s_addr", s_addr, 32'h0);
        chk("rst m0_readdatavalid", {31'b0, m0_readdatavalid}, 32'h0);
        chk("rst m1_readdatavalid", {31'b0, m1_readdatavalid}, 32'h0);
        chk("rst m0_waitrequest idle", {31'b0, m0_waitrequest}, 32'h0);
        m0_read = 1; m0_addr = 32'h100;
        #1;
        chk("rst m0_waitrequest req", {31'b0, m0_waitrequest}, 32'h1);
        @(posedge clk); #1;
        chk("rst hold s_read", {31'b0, s_read}, 32'h0);
        m0_read = 0; m0_addr = 0;
        reset = 1'b0;

        for (int i = 0; i < vecs.size(); i++) begin
            m0_read = vecs[i].r0; m0_write = vecs[i].w0; m0_addr = vecs[i].a0;
            m0_byteenable = vecs[i].be0; m0_writedata = vecs[i].wd0;
            m1_read = vecs[i].r1; m1_write = vecs[i].w1; m1_addr = vecs[i].a1;
            m1_byteenable = vecs[i].be1; m1_writedata = vecs[i].wd1;
            s_waitrequest = vecs[i].sw;
            @(negedge clk);
            check_row(vecs[i], i);
            cycle_end();
        end
        chk("scoreboard drained", sb.size(), 32'h0);

        // asynchronous reset while GNT0 read is being accepted
        m0_read = 1; m0_addr = 32'h100; m0_byteenable = 4'hF;
        m1_read = 0; m1_write = 0; m0_write = 0; s_waitrequest = 0;
        @(negedge clk);
        chk("mid idle s_read", {31'b0, s_read}, 32'h0);
        cycle_end();
        @(negedge clk);
        chk("mid gnt0 s_read", {31'b0, s_read}, 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("mid async s_read", {31'b0, s_read}, 32'h0);
        chk("mid async s_addr", s_addr, 32'h0);
        chk("mid async m0_waitrequest", {31'b0, m0_waitrequest}, 32'h1);
        m0_read = 0;
        @(posedge clk); #1;
        s_readdata = 32'hDEADBEEF;
        reset = 1'b0;
        for (int k = 0; k < 2; k++) begin
            @(negedge clk);
            chk($sformatf("post rst%0d m0_readdatavalid", k), {31'b0, m0_readdatavalid}, 32'h0);
            chk($sformatf("post rst%0d m1_readdatavalid", k), {31'b0, m1_readdatavalid}, 32'h0);
            chk($sformatf("post rst%0d m0_readdata", k), m0_readdata, 32'h0);
            @(posedge clk); #1;
        end
        m0_read = 1; m0_addr = 32'h100; m1_read = 1; m1_addr = 32'h200; m1_byteenable = 4'hF;
        @(negedge clk);
        chk("post rst tie idle m0_waitrequest", {31'b0, m0_waitrequest}, 32'h1);
        @(posedge clk); #1;
        @(negedge clk);
        chk("post rst tie s_addr", s_addr, 32'h100);
        chk("post rst tie m0_waitrequest", {31'b0, m0_waitrequest}, 32'h0);
        chk("post rst tie m1_waitrequest", {31'b0, m1_waitrequest}, 32'h1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
